// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a fixed 16-entry scale melody and drives the
// tone NCO with a phase increment, a tone gate and playback status flags.
// Each note lasts dur x CLOCKS_PER_16TH cycles; its last GAP_CYCLES are silent.
module melody_sequencer #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int CLOCKS_PER_16TH = 6_250_000,
    parameter int GAP_CYCLES      = 250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        loop,
    output logic [31:0] phase_inc,
    output logic        tone_on,
    output logic        playing,
    output logic        melody_end,
    output logic [4:0]  note_index
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [31:0] C16_W = 32'(CLOCKS_PER_16TH);
    localparam logic [31:0] GAP_W = 32'(GAP_CYCLES);

    // Tone frequency for each pitch code; code 0 and unused codes are silent.
    localparam int FREQ_HZ [16] = '{0, 262, 294, 330, 349, 392, 440, 494, 523,
                                    0, 0, 0, 0, 0, 0, 0};

    // Melody: ascending scale, held top C, one rest, descending back to C4.
    localparam logic [3:0] ROM_CODE [16] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                             4'd0, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    localparam logic [2:0] ROM_DUR [16]  = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2,
                                             3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd4};

    // floor(f * 2^32 / CLK_FREQ_HZ), done in 64 bits so the product cannot overflow.
    function automatic logic [31:0] calc_inc(input int freq_hz);
        logic [63:0] num;
        num = 64'(freq_hz) << 32;
        return 32'(num / 64'(CLK_FREQ_HZ));
    endfunction

    logic [31:0] phase_table [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi = gi + 1) begin : g_phase
            assign phase_table[gi] = calc_inc(FREQ_HZ[gi]);
        end
    endgenerate

    state_t      state_reg, state_next;
    logic [3:0]  index_reg, index_next;
    logic [31:0] count_reg, count_next;
    logic        done_reg, done_next;
    logic [31:0] phase_inc_reg, phase_inc_next;
    logic        tone_on_reg, tone_on_next;
    logic        playing_reg, playing_next;
    logic        melody_end_reg, melody_end_next;

    logic [31:0] note_len;
    logic [31:0] tone_last;
    logic        note_end;

    // Length of the current entry and the last counter value of its sounding part.
    always_comb begin
        note_len  = 32'(ROM_DUR[index_reg]) * C16_W;
        tone_last = note_len - GAP_W - 32'd1;
    end

    // Next-state logic; outputs are derived from the next state so they register in step.
    always_comb begin
        state_next      = state_reg;
        index_next      = index_reg;
        count_next      = count_reg + 32'd1;
        done_next       = done_reg;
        melody_end_next = 1'b0;
        note_end        = 1'b0;

        if (!enable) begin
            state_next = IDLE;
            index_next = 4'd0;
            count_next = 32'd0;
            done_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    index_next = 4'd0;
                    count_next = 32'd0;
                    if (!done_reg) begin
                        state_next = NOTE;
                    end
                end
                NOTE: begin
                    if (count_reg == tone_last) begin
                        if (GAP_CYCLES > 0) begin
                            state_next = GAP;
                        end else begin
                            note_end = 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (count_reg == note_len - 32'd1) begin
                        note_end = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            if (note_end) begin
                count_next = 32'd0;
                if (index_reg != 4'd15) begin
                    state_next = NOTE;
                    index_next = index_reg + 4'd1;
                end else begin
                    melody_end_next = 1'b1;
                    index_next      = 4'd0;
                    if (loop) begin
                        state_next = NOTE;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
        end

        playing_next   = (state_next != IDLE);
        phase_inc_next = playing_next ? phase_table[ROM_CODE[index_next]] : 32'd0;
        tone_on_next   = (state_next == NOTE) && (ROM_CODE[index_next] != 4'd0);
    end

    // State and registered outputs; reset returns everything to silent idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            index_reg      <= 4'd0;
            count_reg      <= 32'd0;
            done_reg       <= 1'b0;
            phase_inc_reg  <= 32'd0;
            tone_on_reg    <= 1'b0;
            playing_reg    <= 1'b0;
            melody_end_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            index_reg      <= index_next;
            count_reg      <= count_next;
            done_reg       <= done_next;
            phase_inc_reg  <= phase_inc_next;
            tone_on_reg    <= tone_on_next;
            playing_reg    <= playing_next;
            melody_end_reg <= melody_end_next;
        end
    end

    assign phase_inc  = phase_inc_reg;
    assign tone_on    = tone_on_reg;
    assign playing    = playing_reg;
    assign melody_end = melody_end_reg;
    assign note_index = {1'b0, index_reg};

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed checks of melody_sequencer with short note lengths
// (10 cycles per 16th, 2-cycle gap) against hand-computed phase increments.
module tb_melody_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        loop;
    logic [31:0] phase_inc;
    logic        tone_on;
    logic        playing;
    logic        melody_end;
    logic [4:0]  note_index;

    int n_cmp;
    int n_err;

    // floor(f * 2^32 / 50e6) per melody entry, worked out by hand.
    int exp_phase [16] = '{22505, 25254, 28346, 29978, 33672, 37795, 42434, 44925,
                           0, 42434, 37795, 33672, 29978, 28346, 25254, 22505};
    int exp_dur   [16] = '{1, 1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 4};

    melody_sequencer #(
        .CLK_FREQ_HZ    (50_000_000),
        .CLOCKS_PER_16TH(10),
        .GAP_CYCLES     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .loop      (loop),
        .phase_inc (phase_inc),
        .tone_on   (tone_on),
        .playing   (playing),
        .melody_end(melody_end),
        .note_index(note_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_end);
        check_val({tag, " phase_inc"}, phase_inc, 32'd0);
        check_val({tag, " tone_on"}, 32'(tone_on), 32'd0);
        check_val({tag, " playing"}, 32'(playing), 32'd0);
        check_val({tag, " note_index"}, 32'(note_index), 32'd0);
        check_val({tag, " melody_end"}, 32'(melody_end), 32'(exp_end));
    endtask

    // Follow playback from entry 0 for ncyc cycles; the start edge is the next edge.
    task automatic check_pass(input string tag, input logic me_first, input int ncyc);
        int e;
        int c;
        int len;
        string t;
        e = 0;
        c = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            tick();
            len = exp_dur[e] * 10;
            t = $sformatf("%s e%0d c%0d", tag, e, c);
            check_val({t, " playing"}, 32'(playing), 32'd1);
            check_val({t, " note_index"}, 32'(note_index), 32'(e));
            check_val({t, " phase_inc"}, phase_inc, 32'(exp_phase[e]));
            check_val({t, " tone_on"}, 32'(tone_on),
                      32'((exp_phase[e] != 0) && (c < len - 2)));
            check_val({t, " melody_end"}, 32'(melody_end),
                      32'((cyc == 0) ? me_first : 1'b0));
            c++;
            if (c == len) begin
                c = 0;
                e = (e + 1) % 16;
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        loop   = 1'b0;

        // Reset held for three cycles, then idle with enable low.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("reset", 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_idle("idle", 1'b0);
        end
        $display("reset/idle: %0d compared so far", n_cmp);

        // Single pass without loop: 200 cycles, one end pulse, then stays idle.
        enable = 1'b1;
        check_pass("single", 1'b0, 200);
        tick();
        check_idle("single end", 1'b1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check_idle("after finish", 1'b0);
        end
        $display("single pass: %0d compared so far", n_cmp);

        // One-cycle enable drop clears the finish flag and allows a restart.
        enable = 1'b0;
        tick();
        check_idle("enable pulse", 1'b0);
        enable = 1'b1;
        // Run up to entry 5, counter 3 (cycle 53), then stop.
        check_pass("restart", 1'b0, 54);
        enable = 1'b0;
        tick();
        check_idle("stop mid-note", 1'b0);
        $display("restart + stop: %0d compared so far", n_cmp);

        // Re-enable, run into the gap of entry 2 (cycle 28), then reset.
        enable = 1'b1;
        check_pass("reenable", 1'b0, 29);
        rst_n = 1'b0;
        tick();
        check_idle("reset mid-gap", 1'b0);
        rst_n = 1'b1;
        check_pass("after reset", 1'b0, 15);
        enable = 1'b0;
        tick();
        check_idle("stop before loop", 1'b0);
        $display("reset mid-gap: %0d compared so far", n_cmp);

        // Looping for 450 cycles: end pulses at 200 and 400, no drop in playing.
        loop   = 1'b1;
        enable = 1'b1;
        check_pass("loop p1", 1'b0, 200);
        check_pass("loop p2", 1'b1, 200);
        check_pass("loop p3", 1'b1, 50);
        $display("loop: %0d compared so far", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
